// File: rtl/avmm_lvds_bridge_tx_framer.sv
// avmm_lvds_bridge_tx_framer: tags FIFO read words as data/control and inserts TRAIN, SYNC and IDLE codes,
// with an elastic buffer soaking up input while control codes occupy the line.
module avmm_lvds_bridge_tx_framer #(
  parameter int         DATA_W      = 8,
  parameter int         DEPTH       = 16,
  parameter int         TRAIN_LEN   = 256,
  parameter int         SYNC_PERIOD = 1024,
  parameter logic [7:0] TRAIN_BYTE  = 8'h55,
  parameter logic [7:0] SYNC_BYTE   = 8'hBC,
  parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              retrain_i,
  output logic [DATA_W:0]   tx_data_o,
  output logic              training_o,
  output logic              overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TRAIN_LEN + 1);
  localparam int SW = $clog2(SYNC_PERIOD);
  localparam logic [DATA_W-1:0] TRAIN_CODE = {(DATA_W/8){TRAIN_BYTE}};
  localparam logic [DATA_W-1:0] SYNC_CODE  = {(DATA_W/8){SYNC_BYTE}};
  localparam logic [DATA_W-1:0] IDLE_CODE  = {(DATA_W/8){IDLE_BYTE}};

  typedef enum logic {TRAIN, RUN} state_t;

  state_t            state_q;
  logic [TW-1:0]     train_cnt_q;
  logic [SW-1:0]     sync_cnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W:0]   tx_q;
  logic              training_q, overflow_q;
  logic              empty, full, sync_due, pop, push;

  always_comb begin
    empty    = wr_ptr_q == rd_ptr_q;
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    sync_due = sync_cnt_q == SW'(SYNC_PERIOD - 1);
    pop      = (state_q == RUN) && !retrain_i && !sync_due && !empty;
    push     = valid_i && (!full || pop);
  end

  // A retrain edge emits IDLE with training_o already high; the TRAIN_LEN TRAIN words follow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= TRAIN;
      train_cnt_q <= '0;
      sync_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tx_q        <= {1'b1, IDLE_CODE};
      training_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (valid_i && !push) overflow_q <= 1'b1;
      if (state_q == TRAIN) begin
        tx_q        <= {1'b1, TRAIN_CODE};
        training_q  <= 1'b1;
        train_cnt_q <= train_cnt_q + 1'b1;
        if (train_cnt_q == TW'(TRAIN_LEN - 1)) begin
          state_q    <= RUN;
          sync_cnt_q <= '0;
        end
      end else if (retrain_i) begin
        state_q     <= TRAIN;
        train_cnt_q <= '0;
        training_q  <= 1'b1;
        tx_q        <= {1'b1, IDLE_CODE};
      end else begin
        training_q <= 1'b0;
        sync_cnt_q <= sync_due ? '0 : sync_cnt_q + 1'b1;
        tx_q       <= sync_due ? {1'b1, SYNC_CODE} :
                      !empty   ? {1'b0, mem_q[rd_ptr_q[AW-1:0]]} : {1'b1, IDLE_CODE};
      end
    end
  end

  assign tx_data_o  = tx_q;
  assign training_o = training_q;
  assign overflow_o = overflow_q;
endmodule

// File: doc/avmm_lvds_bridge_tx_framer.md
Name: avmm_lvds_bridge_tx_framer

Overview:
Downstream of the TX FIFO in the rdclk domain, it consumes the FIFO's narrow read words (q/valid) and produces the per-cycle word for the LVDS transmitter. It tags each output word as data or control. It emits a training pattern after reset or on request, periodic SYNC words and IDLE fill. A small internal elastic buffer absorbs input while training/SYNC occupy the line, because the FIFO drains without backpressure.

Parameters:
DATA_W, 8, width of input word and output payload; multiple of 8 (equals FIFO read width).
DEPTH, 16, elastic buffer depth in words; power of 2, >= 2.
TRAIN_LEN, 256, number of TRAIN words per training sequence; >= 1.
SYNC_PERIOD, 1024, RUN-state cycles between SYNC words; >= 2.
TRAIN_BYTE, 8'h55, byte replicated DATA_W/8 times to form the TRAIN code.
SYNC_BYTE, 8'hBC, byte replicated to form the SYNC code.
IDLE_BYTE, 8'h00, byte replicated to form the IDLE code.

Ports:
clk_i  in  1  single clock (the FIFO rdclk); reset is synchronous and active-high
rst_i  in  1  synchronous, active-high reset
data_i  in  DATA_W  input word from the TX FIFO
valid_i  in  1  data_i valid; sampled every cycle, no ready
retrain_i  in  1  single-cycle request to restart training
tx_data_o  out  DATA_W+1  bit DATA_W = K flag (1 = control); bits DATA_W-1:0 = payload/code
training_o  out  1  high while in TRAIN
overflow_o  out  1  sticky: an input word was dropped

Behaviour:
- Reset (rst_i high at an edge): tx_data_o = {1'b1, IDLE}, training_o = 0, overflow_o = 0, buffer emptied, state TRAIN, train counter = 0, sync counter = 0. All outputs are registered.
- States: TRAIN, RUN.
- TRAIN: each cycle loads {1, TRAIN} and sets training_o = 1 for exactly TRAIN_LEN cycles after reset release, then enters RUN. The buffer accepts writes but is not read.
- RUN, per-cycle output priority:
  - If sync counter == SYNC_PERIOD-1: load {1, SYNC}; the buffer is not read.
  - Else if the buffer is non-empty: load {0, head} and pop.
  - Else: load {1, IDLE}.
- Sync counter: increments every RUN cycle, wraps SYNC_PERIOD-1 -> 0 and is cleared on entering RUN. The first SYNC therefore appears on the SYNC_PERIOD-th RUN cycle, then every SYNC_PERIOD cycles exactly.
- Latency: a word sampled at edge N with an empty buffer and no SYNC due appears on tx_data_o after edge N+1. There is no bypass path; all data passes through the buffer.
- Buffer:
  - Order is strictly FIFO.
  - A write and a pop in the same cycle are legal at any fill, including full.
  - If a write occurs while full with no pop, the word is dropped, the buffer is unchanged and overflow_o goes 1, held until reset.
  - Pointers are log2(DEPTH) bits plus one wrap bit.
- retrain_i high in RUN: the next edge enters TRAIN. The train counter is cleared and training_o rises. The buffer contents are retained and drain after training. retrain_i is ignored while in TRAIN.
- Reset mid-operation: buffered data is discarded and the block follows the reset values above.
- valid_i is ignored while rst_i is high.

Test Plan:
(All scenarios use DATA_W=8, DEPTH=4, TRAIN_LEN=4, SYNC_PERIOD=8.)
1. Release reset with no input -> 4 cycles of 9'h155 with training_o=1, then 9'h100 (IDLE) with training_o=0; SYNC 9'h1BC on RUN cycles 8, 16, 24.
2. In RUN, buffer empty, single valid_i with data 8'h3C at edge N -> tx_data_o = 9'h03C after edge N+1 only; IDLE before and after.
3. Drive 3 words (01,02,03) during TRAIN -> after training, data 001, 002, 003 on the first 3 RUN cycles, in order; overflow_o stays 0.
4. Continuous valid_i from RUN cycle 0 (words 10,11,...) -> SYNC on cycle 7 delays the stream by one with no loss; no overflow within 16 cycles.
5. Drive 6 words during TRAIN -> 4 buffered, words 5 and 6 dropped, overflow_o=1 and sticky until rst_i; RUN outputs words 1-4 only.
6. Buffer holds 2 words, assert retrain_i -> 4 TRAIN words, then both buffered words output. Assert rst_i mid-stream -> next output IDLE and buffer empty.
